// File: rtl/tpu_pkg.sv
// Shared definitions for blocks that time-share the tpu_simple array:
// scheduler state encoding, default array size and a job-size check.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } sched_state_e;

    localparam int TPU_SIZE = 4;

    function automatic logic size_legal(input logic [7:0] sz, input int max_size);
        return (sz != 8'd0) && (int'({24'd0, sz}) <= max_size);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping
// modulo NUM_REQ (which need not be a power of two).
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    ptr_i,
    output logic [IDXW-1:0]    grant_o,
    output logic               any_req_o
);

    logic [IDXW-1:0] idx_s;

    // Scan from the farthest candidate back to ptr_i so the closest one wins.
    always_comb begin
        grant_o   = '0;
        idx_s     = '0;
        any_req_o = |req_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_s = IDXW'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx_s]) begin
                grant_o = idx_s;
            end else begin
                grant_o = grant_o;
            end
        end
    end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Round-robin owner of one tpu_simple array: arbitrates requesters, launches
// jobs, watches for hung runs and returns a per-requester response.
module tpu_job_scheduler
    import tpu_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int SIZE      = TPU_SIZE,
    parameter  int TIMEOUT   = 256,
    parameter  int CNT_WIDTH = 16,
    localparam int IDXW      = $clog2(NUM_REQ),
    localparam int WDW       = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_size,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic                   resp_err,
    output logic [IDXW-1:0]        sel,
    output logic                   sel_valid,
    output logic                   tpu_start,
    output logic [7:0]             tpu_size,
    output logic                   tpu_abort,
    input  logic                   tpu_busy,
    input  logic                   tpu_done,
    output logic [CNT_WIDTH-1:0]   jobs_ok,
    output logic [CNT_WIDTH-1:0]   jobs_err
);

    sched_state_e          state_q, state_d;
    logic [IDXW-1:0]       sel_q, sel_d, ptr_q, ptr_d, grant_s;
    logic [7:0]            size_q, size_d, cand_size_s;
    logic [WDW-1:0]        wd_q, wd_d;
    logic                  start_q, start_d, sel_valid_q, sel_valid_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [CNT_WIDTH-1:0]  ok_q, ok_d, err_cnt_q, err_cnt_d;
    logic                  any_req_s, abort_s;
    logic                  unused_busy_s;

    // Completion is tracked from tpu_done alone; busy is informational.
    assign unused_busy_s = tpu_busy;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .grant_o   (grant_s),
        .any_req_o (any_req_s)
    );

    assign cand_size_s = req_size[{grant_s, 3'b000} +: 8];

    // State and output registers; async reset drops any in-flight job silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            ptr_q        <= '0;
            size_q       <= 8'd0;
            wd_q         <= '0;
            start_q      <= 1'b0;
            sel_valid_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            ok_q         <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            size_q       <= size_d;
            wd_q         <= wd_d;
            start_q      <= start_d;
            sel_valid_q  <= sel_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            ok_q         <= ok_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state logic; start/response pulses are set on entry to their state.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        size_d       = size_q;
        wd_d         = wd_q;
        start_d      = 1'b0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        ok_d         = ok_q;
        err_cnt_d    = err_cnt_q;
        abort_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    sel_d  = grant_s;
                    size_d = cand_size_s;
                    if (size_legal(cand_size_s, SIZE)) begin
                        state_d = ST_LAUNCH;
                        start_d = 1'b1;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = NUM_REQ'(1'b1) << grant_s;
                        resp_err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done on the last watchdog cycle still counts as success.
                if (tpu_done) begin
                    state_d      = ST_RESP;
                    resp_valid_d = NUM_REQ'(1'b1) << sel_q;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    abort_s      = 1'b1;
                    state_d      = ST_RESP;
                    resp_valid_d = NUM_REQ'(1'b1) << sel_q;
                    resp_err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_RESP: begin
                if (resp_err_q) begin
                    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);
                end else begin
                    ok_d = (ok_q == '1) ? ok_q : ok_q + CNT_WIDTH'(1);
                end
                ptr_d   = (sel_q == IDXW'(NUM_REQ - 1)) ? '0 : sel_q + IDXW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sel_valid_d = (state_d != ST_IDLE);
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign tpu_start  = start_q;
    assign tpu_size   = size_q;
    assign tpu_abort  = abort_s;
    assign jobs_ok    = ok_q;
    assign jobs_err   = err_cnt_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Scoreboard bench for tpu_job_scheduler: a job-level model predicts grant
// order, launches and responses; a monitor compares what the DUT presents.
module tb_tpu_job_scheduler;

    localparam int NREQ = 4;
    localparam int SZ   = 4;
    localparam int TO   = 16;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = 4'd0;
    logic [31:0]     req_size = 32'd0;
    logic [3:0]      resp_valid;
    logic            resp_err;
    logic [1:0]      sel;
    logic            sel_valid, tpu_start, tpu_abort;
    logic [7:0]      tpu_size;
    logic            tpu_busy = 1'b0;
    logic            tpu_done = 1'b0;
    logic [CW-1:0]   jobs_ok, jobs_err;

    typedef struct { int idx; int size; int exp_start; } launch_t;
    typedef struct { int idx; bit err; bit launched; int delay; } resp_t;

    launch_t lq[$];
    resp_t   rq[$];
    int      dq[$];
    int      done_cycles[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int m_ptr = 0, m_ok = 0, m_err = 0, m_aborts = 0;
    int seen_aborts = 0, abort_base = 0;
    int last_start = -1000;
    int sizes[4];
    int delays[4];

    tpu_job_scheduler #(.NUM_REQ(NREQ), .SIZE(SZ), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_size(req_size),
        .resp_valid(resp_valid), .resp_err(resp_err), .sel(sel), .sel_valid(sel_valid),
        .tpu_start(tpu_start), .tpu_size(tpu_size), .tpu_abort(tpu_abort),
        .tpu_busy(tpu_busy), .tpu_done(tpu_done), .jobs_ok(jobs_ok), .jobs_err(jobs_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expectation at t=%0t", name, $time);
    endtask

    // Job-level reference: grant order of a held request mask from the model pointer.
    task automatic issue(input logic [3:0] mask);
        logic [3:0] pend;
        int p, g;
        bit first, legal, tmo;
        pend  = mask;
        p     = m_ptr;
        first = 1'b1;
        for (int k = 0; k < NREQ; k++) req_size[8*k +: 8] = 8'(sizes[k]);
        while (pend != 4'd0) begin
            g = -1;
            for (int s = 0; s < NREQ; s++)
                if (g < 0 && pend[(p + s) % NREQ]) g = (p + s) % NREQ;
            legal = (sizes[g] >= 1) && (sizes[g] <= SZ);
            tmo   = delays[g] > TO;
            if (legal) begin
                lq.push_back('{idx: g, size: sizes[g], exp_start: first ? cyc + 1 : -1});
                dq.push_back(delays[g]);
                rq.push_back('{idx: g, err: tmo, launched: 1'b1, delay: delays[g]});
                if (tmo) m_aborts++;
            end else begin
                rq.push_back('{idx: g, err: 1'b1, launched: 1'b0, delay: 0});
            end
            if (!legal || tmo) m_err++; else m_ok++;
            first   = 1'b0;
            pend[g] = 1'b0;
            p       = (g + 1) % NREQ;
        end
        m_ptr = p;
        req   = mask;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (req != 4'd0 && n < budget) begin
            @(negedge clk);
            req = req & ~resp_valid;
            n++;
        end
        chk("drain_req_cleared", {28'd0, req}, 32'd0);
        repeat (4) @(negedge clk);
        chk("jobs_ok", {16'd0, jobs_ok}, m_ok);
        chk("jobs_err", {16'd0, jobs_err}, m_err);
        chk("resp_pending", rq.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, {28'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_sel"}, {30'd0, sel}, 32'd0);
        chk({tag, "_sel_valid"}, {31'd0, sel_valid}, 32'd0);
        chk({tag, "_tpu_start"}, {31'd0, tpu_start}, 32'd0);
        chk({tag, "_tpu_size"}, {24'd0, tpu_size}, 32'd0);
        chk({tag, "_tpu_abort"}, {31'd0, tpu_abort}, 32'd0);
        chk({tag, "_jobs_ok"}, {16'd0, jobs_ok}, 32'd0);
        chk({tag, "_jobs_err"}, {16'd0, jobs_err}, 32'd0);
    endtask

    // TPU stand-in: done pulses `delay` cycles after start; delays past 19 never finish.
    always @(negedge clk) begin
        if (rst) begin
            done_cycles.delete();
            tpu_done <= 1'b0;
            tpu_busy <= 1'b0;
        end else begin
            if (tpu_start && dq.size() > 0) begin
                int d;
                d = dq.pop_front();
                if (d <= 19) done_cycles.push_back(cyc + d);
            end
            tpu_done <= 1'b0;
            foreach (done_cycles[k]) if (done_cycles[k] == cyc) tpu_done <= 1'b1;
            tpu_busy <= tpu_start ? 1'b1 : (tpu_done ? 1'b0 : tpu_busy);
        end
    end

    // Monitor: sample mid-cycle, after input changes have settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (tpu_start) begin
                if (lq.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    launch_t l;
                    l = lq.pop_front();
                    chk("start_sel", {30'd0, sel}, l.idx);
                    chk("start_size", {24'd0, tpu_size}, l.size);
                    chk("start_sel_valid", {31'd0, sel_valid}, 32'd1);
                    if (l.exp_start >= 0) chk("start_latency", cyc, l.exp_start);
                    last_start = cyc;
                end
            end
            if (tpu_abort) begin
                seen_aborts++;
                chk("abort_cycle", cyc, last_start + TO);
            end
            if (resp_valid != 4'd0) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("resp_onehot", {28'd0, resp_valid}, 32'd1 << r.idx);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    chk("resp_sel", {30'd0, sel}, r.idx);
                    chk("resp_sel_valid", {31'd0, sel_valid}, 32'd1);
                    if (r.launched)
                        chk("resp_cycle", cyc, r.err ? last_start + TO + 1 : last_start + r.delay + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin sizes[k] = 2; delays[k] = 3; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // single job
        @(negedge clk);
        sizes[0] = 2; delays[0] = 6;
        issue(4'b0001); drain(200);

        // fairness: two full rounds with all requesters held
        for (int k = 0; k < NREQ; k++) begin sizes[k] = 2; delays[k] = 3 + k; end
        issue(4'b1111); drain(300);
        issue(4'b1111); drain(300);

        // rejected sizes
        sizes[2] = 0; issue(4'b0100); drain(100);
        sizes[2] = 5; issue(4'b0100); drain(100);

        // timeout, then a normal job; then stale done landing in IDLE
        sizes[0] = 3; delays[0] = 100; issue(4'b0001); drain(200);
        sizes[1] = 1; delays[1] = 4;   issue(4'b0010); drain(200);
        sizes[0] = 4; delays[0] = 18;  issue(4'b0001); drain(200);

        // done on the timeout cycle; stale done during RESP
        sizes[3] = 4; delays[3] = 16; issue(4'b1000); drain(200);
        sizes[3] = 2; delays[3] = 17; issue(4'b1000); drain(200);

        // reset in the middle of a job after the pointer has moved
        sizes[2] = 2; delays[2] = 3;  issue(4'b0100); drain(200);
        sizes[3] = 2; delays[3] = 10; issue(4'b1000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midjob_reset");
        lq.delete(); rq.delete(); dq.delete();
        req = 4'd0;
        m_ptr = 0; m_ok = 0; m_err = 0; m_aborts = 0;
        abort_base = seen_aborts;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sizes[1] = 3; delays[1] = 5; sizes[3] = 1; delays[3] = 2;
        issue(4'b1010); drain(200);

        // randomized batches
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = $urandom_range(0, 9);
                sizes[k] = (r == 0) ? 0 : (r == 1) ? $urandom_range(5, 9) : $urandom_range(1, SZ);
                r = $urandom_range(0, 9);
                delays[k] = (r < 6) ? $urandom_range(1, 16) : (r == 6) ? 16 :
                            (r == 7) ? $urandom_range(17, 19) : 100;
            end
            issue(4'($urandom_range(1, 15)));
            drain(400);
        end

        chk("abort_count", seen_aborts - abort_base, m_aborts);
        chk("launch_pending", lq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
